// File: rtl/slave_burst_sequencer.sv
// Burst sequencer: accepts one master transaction at a time and walks the memory controller
// through an address phase, one or more data beats, and a single-cycle completion phase.
module slave_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [3:0]            Burst,
    input  logic [1:0]            Size,
    input  logic                  Write,
    input  logic                  MemReady,
    output logic [8:0]            Control,
    output logic                  En,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  Ack,
    output logic                  BeatDone,
    output logic                  Done,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAddr = 2'b01,
        StData = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            remaining_q, remaining_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] step;
    logic                  beat;

    // Beat stride in bytes; wraps modulo 2^ADDR_WIDTH through plain truncating addition.
    assign step = ADDR_WIDTH'(1) << size_q;
    assign beat = (state_q == StData) && MemReady;

    // State and latched transaction fields; synchronous reset clears everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            size_q      <= size_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
        end
    end

    // Next-state logic: Req is only looked at in idle, MemReady only in the data phase.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        size_d      = size_q;
        write_d     = write_q;
        addr_d      = addr_q;
        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    state_d     = StAddr;
                    remaining_d = Burst;
                    size_d      = Size;
                    write_d     = Write;
                    addr_d      = Addr;
                end
            end
            StAddr: state_d = StData;
            StData: begin
                if (beat) begin
                    if (remaining_q == 4'd0) begin
                        // Last beat: address stays on the final beat.
                        state_d = StDone;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                        addr_d      = addr_q + step;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state and latched fields.
    always_comb begin
        Control  = {state_q, remaining_q, size_q, write_q};
        MemAddr  = addr_q;
        En       = (state_q == StAddr) || (state_q == StData);
        Ack      = (state_q == StAddr);
        BeatDone = beat;
        Done     = (state_q == StDone);
        Busy     = (state_q != StIdle);
    end

endmodule
